// File: rtl/one_wire_resp_ctrl_if.sv
// Bus bundle between the 1-wire engine side (master) and the response
// packetiser (slave): transaction results, data-buffer read port, FIFO write port.
interface one_wire_resp_ctrl_if #(
  parameter int FIFO_WIDTH            = 8,
  parameter int UID_SERIAL_DATA_WIDTH = 56
);
  logic                             start;
  logic [2:0]                       read_command;
  logic [7:0]                       ROM_command;
  logic [7:0]                       Fun_cmd;
  logic [3:0]                       data_length;
  logic                             read_write;
  logic [UID_SERIAL_DATA_WIDTH-1:0] UID_Data;
  logic                             presence;
  logic [4:0]                       rd_address;
  logic [7:0]                       rd_data;
  logic                             fifo_full;
  logic [FIFO_WIDTH-1:0]            fifo_write_data;
  logic                             fifo_write_enable;
  logic                             busy;
  logic                             done;

  modport master (
    output start, read_command, ROM_command, Fun_cmd, data_length, read_write,
           UID_Data, presence, rd_data, fifo_full,
    input  rd_address, fifo_write_data, fifo_write_enable, busy, done
  );

  modport slave (
    input  start, read_command, ROM_command, Fun_cmd, data_length, read_write,
           UID_Data, presence, rd_data, fifo_full,
    output rd_address, fifo_write_data, fifo_write_enable, busy, done
  );
endinterface

// File: rtl/one_wire_resp_ctrl.sv
// Serialises a finished 1-wire transaction into response-FIFO bytes.
// Define OW_RESP_STATUS_EN to append a {presence, 7'b0} status byte to every packet.
module one_wire_resp_ctrl #(
  parameter int FIFO_WIDTH            = 8,
  parameter int UID_SERIAL_DATA_WIDTH = 56
) (
  input logic                 clk,
  input logic                 rst,
  one_wire_resp_ctrl_if.slave bus
);

`ifdef OW_RESP_STATUS_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    IDLE, HDR, ROM, UID, FUNC, RD_REQ, RD_WAIT, DATA, STATUS, FINISH
  } state_t;

  state_t                           state_q;
  logic [2:0]                       rd_cmd_q;
  logic                             rw_q;
  logic [3:0]                       len_q;
  logic [7:0]                       rom_q;
  logic [7:0]                       fun_q;
  logic [UID_SERIAL_DATA_WIDTH-1:0] uid_q;
  logic                             pres_q;
  logic [2:0]                       uid_cnt_q;
  logic [4:0]                       rd_addr_q;
  logic [FIFO_WIDTH-1:0]            wdata_q;
  logic                             wvld_q;
  logic                             busy_q;
  logic                             done_q;

  logic                  accept;
  state_t                tail_state;
  logic                  tail_vld;
  logic [FIFO_WIDTH-1:0] tail_data;
  state_t                pf_state;
  logic                  pf_vld;

  // wvld_q marks a pending byte; it only leaves when the FIFO has room.
  assign accept     = wvld_q & ~bus.fifo_full;
  assign tail_state = STATUS_EN ? STATUS : FINISH;
  assign tail_vld   = STATUS_EN;
  assign tail_data  = FIFO_WIDTH'({pres_q, 7'b0});
  assign pf_state   = rw_q ? RD_REQ : tail_state;
  assign pf_vld     = rw_q ? 1'b0 : tail_vld;

  assign bus.fifo_write_enable = accept;
  assign bus.fifo_write_data   = wdata_q;
  assign bus.rd_address        = rd_addr_q;
  assign bus.busy              = busy_q;
  assign bus.done              = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rd_cmd_q  <= '0;
      rw_q      <= 1'b0;
      len_q     <= '0;
      rom_q     <= '0;
      fun_q     <= '0;
      uid_q     <= '0;
      pres_q    <= 1'b0;
      uid_cnt_q <= '0;
      rd_addr_q <= '0;
      wdata_q   <= '0;
      wvld_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          rd_cmd_q  <= bus.read_command;
          rw_q      <= bus.read_write;
          len_q     <= bus.data_length;
          rom_q     <= bus.ROM_command;
          fun_q     <= bus.Fun_cmd;
          uid_q     <= bus.UID_Data;
          pres_q    <= bus.presence;
          uid_cnt_q <= '0;
          rd_addr_q <= '0;
          wdata_q   <= FIFO_WIDTH'({bus.data_length, bus.read_write, bus.read_command});
          wvld_q    <= 1'b1;
          busy_q    <= 1'b1;
          state_q   <= HDR;
        end
        HDR: if (accept) begin
          wdata_q <= FIFO_WIDTH'(rom_q);
          state_q <= ROM;
        end
        ROM: if (accept) begin
          if (rd_cmd_q == 3'd2) begin
            wdata_q <= FIFO_WIDTH'(uid_q[7:0]);
            state_q <= UID;
          end else if (rd_cmd_q == 3'd0) begin
            wdata_q <= FIFO_WIDTH'(fun_q);
            state_q <= FUNC;
          end else begin
            wdata_q <= tail_data;
            wvld_q  <= pf_vld;
            state_q <= pf_state;
            if (pf_state == FINISH) begin
              done_q <= 1'b1;
              busy_q <= 1'b0;
            end
          end
        end
        UID: if (accept) begin
          if (uid_cnt_q == 3'd6) begin
            wdata_q <= FIFO_WIDTH'(fun_q);
            state_q <= FUNC;
          end else begin
            uid_cnt_q <= uid_cnt_q + 3'd1;
            wdata_q   <= FIFO_WIDTH'(uid_q[{uid_cnt_q + 3'd1, 3'b000} +: 8]);
          end
        end
        FUNC: if (accept) begin
          wdata_q <= tail_data;
          wvld_q  <= pf_vld;
          state_q <= pf_state;
          if (pf_state == FINISH) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        RD_REQ: state_q <= RD_WAIT;
        // rd_data now reflects the address presented during RD_REQ.
        RD_WAIT: begin
          wdata_q <= FIFO_WIDTH'(bus.rd_data);
          wvld_q  <= 1'b1;
          state_q <= DATA;
        end
        DATA: if (accept) begin
          if (rd_addr_q == {1'b0, len_q}) begin
            wdata_q <= tail_data;
            wvld_q  <= tail_vld;
            state_q <= tail_state;
            if (!STATUS_EN) begin
              done_q <= 1'b1;
              busy_q <= 1'b0;
            end
          end else begin
            rd_addr_q <= rd_addr_q + 5'd1;
            wvld_q    <= 1'b0;
            state_q   <= RD_REQ;
          end
        end
        STATUS: if (accept) begin
          wvld_q  <= 1'b0;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= FINISH;
        end
        FINISH:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_one_wire_resp_ctrl.sv
// Self-checking bench for one_wire_resp_ctrl: packets are predicted from the
// byte-order rules as a list, with random FIFO backpressure and field scrambling.
module tb_one_wire_resp_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  one_wire_resp_ctrl_if #(.FIFO_WIDTH(8), .UID_SERIAL_DATA_WIDTH(56)) bus ();

  one_wire_resp_ctrl #(.FIFO_WIDTH(8), .UID_SERIAL_DATA_WIDTH(56)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] mem [32];
  always @(posedge clk) bus.rd_data <= mem[bus.rd_address];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] act_q[$];
  int         act_cyc[$];
  int         full_viol = 0;
  int         busy_done_viol = 0;
  int         done_total = 0;
  int         last_done_cyc = -1;
  int         max_addr = 0;

  always @(negedge clk) begin
    if (bus.fifo_write_enable) begin
      act_q.push_back(bus.fifo_write_data);
      act_cyc.push_back(cyc);
      if (bus.fifo_full) full_viol <= full_viol + 1;
    end
    if (bus.done) begin
      done_total    <= done_total + 1;
      last_done_cyc <= cyc;
      if (bus.busy) busy_done_viol <= busy_done_viol + 1;
    end
    if (int'(bus.rd_address) > max_addr) max_addr <= int'(bus.rd_address);
  end

  // Reference: the packet is simply the concatenation of its applicable sections.
  logic [7:0] exp_q[$];
  task automatic model(input logic [2:0] rd, input logic rw, input logic [3:0] len,
                       input logic [7:0] rom, input logic [7:0] fun,
                       input logic [55:0] uid, input logic pres);
    exp_q = {};
    exp_q.push_back({len, rw, rd});
    exp_q.push_back(rom);
    if (rd == 3'd2) for (int k = 0; k < 7; k++) exp_q.push_back(uid[8*k +: 8]);
    if (rd == 3'd0 || rd == 3'd2) exp_q.push_back(fun);
    if (rw) for (int k = 0; k <= int'(len); k++) exp_q.push_back(mem[k]);
`ifdef OW_RESP_STATUS_EN
    exp_q.push_back({pres, 7'b0});
`endif
  endtask

  function automatic int first_diff(input int base);
    int na = act_q.size() - base;
    int ne = exp_q.size();
    for (int i = 0; i < ((na > ne) ? na : ne); i++) begin
      if (i >= na || i >= ne) return i;
      if (act_q[base+i] !== exp_q[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [7:0] act_at(input int i);
    return (i >= 0 && i < act_q.size()) ? act_q[i] : 8'hxx;
  endfunction

  function automatic logic [7:0] exp_at(input int i);
    return (i >= 0 && i < exp_q.size()) ? exp_q[i] : 8'hxx;
  endfunction

  task automatic scramble_inputs();
    bus.read_command = 3'($urandom);
    bus.read_write   = 1'($urandom);
    bus.data_length  = 4'($urandom);
    bus.ROM_command  = 8'($urandom);
    bus.Fun_cmd      = 8'($urandom);
    bus.UID_Data     = {24'($urandom), 32'($urandom)};
    bus.presence     = 1'($urandom);
  endtask

  // Drives one transaction; inputs are scrambled right after start to prove they were latched.
  task automatic send(input logic [2:0] rd, input logic rw, input logic [3:0] len,
                      input logic [7:0] rom, input logic [7:0] fun, input logic [55:0] uid,
                      input logic pres, input int full_pct, input int hold_from,
                      input int hold_len, input int restart_at,
                      output logic busy_seen, output logic done_once, output logic timed_out);
    int n;
    model(rd, rw, len, rom, fun, uid, pres);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.read_command = rd; bus.read_write = rw; bus.data_length = len;
    bus.ROM_command = rom; bus.Fun_cmd = fun; bus.UID_Data = uid; bus.presence = pres;
    @(posedge clk); #1;
    busy_seen = bus.busy;
    bus.start = 1'b0;
    scramble_inputs();
    n = 0;
    timed_out = 1'b0;
    while (!bus.done) begin
      if (n >= 400) begin
        timed_out = 1'b1;
        break;
      end
      bus.start = (n == restart_at);
      bus.fifo_full = (n >= hold_from && n < hold_from + hold_len) ||
                      (int'($urandom_range(99, 0)) < full_pct);
      @(posedge clk); #1;
      n++;
    end
    bus.start = 1'b0;
    bus.fifo_full = 1'b0;
    @(posedge clk); #1;
    done_once = !bus.done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    tests_run++; if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", bus.done); end
    tests_run++; if (bus.fifo_write_enable !== 1'b0) begin tests_failed++; $display("FAIL reset_we: got %b want 0", bus.fifo_write_enable); end
    tests_run++; if (bus.fifo_write_data !== 8'h00) begin tests_failed++; $display("FAIL reset_wdata: got %h want 00", bus.fifo_write_data); end
    tests_run++; if (bus.rd_address !== 5'd0) begin tests_failed++; $display("FAIL reset_addr: got %0d want 0", bus.rd_address); end
    rst = 1'b0;
  endtask

  task automatic test_rom_func();
    logic b, d1, to;
    int base, d, span, lastc;
    base = act_q.size();
    send(3'd0, 1'b0, 4'd0, 8'hCC, 8'h44, 56'h0, 1'b0, 0, -1, 0, -1, b, d1, to);
    d = first_diff(base);
    tests_run++; if (d >= 0 || to) begin tests_failed++; $display("FAIL s1_bytes: idx %0d got %h want %h (got %0d bytes, want %0d, timeout %b)", d, act_at(base+d), exp_at(d), act_q.size()-base, exp_q.size(), to); end
    tests_run++; if (b !== 1'b1) begin tests_failed++; $display("FAIL s1_busy_after_start: got %b want 1", b); end
    span  = (act_cyc.size() >= base + 3) ? act_cyc[base+2] - act_cyc[base] : -1;
    lastc = (act_cyc.size() >= base + 3) ? act_cyc[base+2] : -100;
    tests_run++; if (span != 2) begin tests_failed++; $display("FAIL s1_back_to_back: span %0d cycles want 2", span); end
`ifndef OW_RESP_STATUS_EN
    tests_run++; if (last_done_cyc != lastc + 1) begin tests_failed++; $display("FAIL s1_done_timing: done at %0d want %0d", last_done_cyc, lastc + 1); end
`endif
    tests_run++; if (d1 !== 1'b1) begin tests_failed++; $display("FAIL s1_done_pulse: done still high, got 0 want 1"); end
  endtask

  task automatic test_uid();
    logic b, d1, to;
    int base, d;
    base = act_q.size();
    send(3'd2, 1'b0, 4'd0, 8'h55, 8'h9A, 56'h01020304050607, 1'b1, 0, -1, 0, -1, b, d1, to);
    d = first_diff(base);
    tests_run++; if (d >= 0 || to) begin tests_failed++; $display("FAIL s2_bytes: idx %0d got %h want %h (got %0d bytes, want %0d)", d, act_at(base+d), exp_at(d), act_q.size()-base, exp_q.size()); end
    tests_run++; if (act_at(base+2) !== 8'h07 || act_at(base+8) !== 8'h01) begin tests_failed++; $display("FAIL s2_uid_order: got %h..%h want 07..01", act_at(base+2), act_at(base+8)); end
  endtask

  task automatic test_data();
    logic b, d1, to;
    int base, d;
    for (int i = 0; i < 32; i++) mem[i] = 8'hA0 + 8'(i);
    base = act_q.size();
    send(3'd0, 1'b1, 4'd3, 8'hCC, 8'hBE, 56'h0, 1'b0, 0, -1, 0, -1, b, d1, to);
    d = first_diff(base);
    tests_run++; if (d >= 0 || to) begin tests_failed++; $display("FAIL s3_bytes: idx %0d got %h want %h (got %0d bytes, want %0d)", d, act_at(base+d), exp_at(d), act_q.size()-base, exp_q.size()); end
    tests_run++; if (act_at(base) !== 8'h38) begin tests_failed++; $display("FAIL s3_header: got %h want 38", act_at(base)); end
  endtask

  task automatic test_backpressure();
    logic b, d1, to;
    int base, d, fv, gap;
    fv = full_viol;
    base = act_q.size();
    send(3'd2, 1'b0, 4'd0, 8'h33, 8'h77, {24'($urandom), 32'($urandom)}, 1'b0, 0, 4, 5, -1, b, d1, to);
    d = first_diff(base);
    tests_run++; if (d >= 0 || to) begin tests_failed++; $display("FAIL s4_bytes: idx %0d got %h want %h (got %0d bytes, want %0d)", d, act_at(base+d), exp_at(d), act_q.size()-base, exp_q.size()); end
    tests_run++; if (full_viol != fv) begin tests_failed++; $display("FAIL s4_write_while_full: got %0d writes want 0", full_viol - fv); end
    gap = (act_cyc.size() >= base + 5) ? act_cyc[base+4] - act_cyc[base+3] : -1;
    tests_run++; if (gap != 6) begin tests_failed++; $display("FAIL s4_stall_gap: got %0d cycles want 6", gap); end
  endtask

  task automatic test_busy_restart_and_reset();
    logic b, d1, to;
    int base, d, dt, n, sz;
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    dt = done_total;
    base = act_q.size();
    send(3'd0, 1'b1, 4'd7, 8'h11, 8'h22, 56'h0, 1'b1, 0, -1, 0, 3, b, d1, to);
    repeat (25) @(posedge clk);
    #1;
    d = first_diff(base);
    tests_run++; if (d >= 0 || to) begin tests_failed++; $display("FAIL s5_restart_ignored: idx %0d got %h want %h (got %0d bytes, want %0d)", d, act_at(base+d), exp_at(d), act_q.size()-base, exp_q.size()); end
    tests_run++; if (done_total - dt != 1) begin tests_failed++; $display("FAIL s5_single_done: got %0d dones want 1", done_total - dt); end

    base = act_q.size();
    @(posedge clk); #1;
    bus.start = 1'b1; bus.read_command = 3'd0; bus.read_write = 1'b1; bus.data_length = 4'd15;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 0;
    while (!(act_q.size() - base >= 4 && bus.fifo_write_enable) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    tests_run++; if (n >= 100) begin tests_failed++; $display("FAIL s5_reach_data: got timeout want DATA write"); end
    rst = 1'b1;
    @(posedge clk); #1;
    tests_run++; if ({bus.busy, bus.done, bus.fifo_write_enable, bus.fifo_write_data, bus.rd_address} !== 16'h0) begin
      tests_failed++; $display("FAIL s5_reset_outputs: got busy %b done %b we %b wdata %h addr %0d want all 0", bus.busy, bus.done, bus.fifo_write_enable, bus.fifo_write_data, bus.rd_address);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    sz = act_q.size();
    dt = done_total;
    repeat (30) @(posedge clk);
    #1;
    tests_run++; if (act_q.size() != sz || done_total != dt || bus.busy !== 1'b0) begin
      tests_failed++; $display("FAIL s5_abandoned: got %0d writes %0d dones busy %b want 0 0 0", act_q.size() - sz, done_total - dt, bus.busy);
    end

    max_addr = 0;
    base = act_q.size();
    send(3'd2, 1'b1, 4'd15, 8'h5A, 8'hA5, {24'($urandom), 32'($urandom)}, 1'b1, 25, -1, 0, -1, b, d1, to);
    d = first_diff(base);
    tests_run++; if (d >= 0 || to) begin tests_failed++; $display("FAIL s5_after_reset_full_packet: idx %0d got %h want %h (got %0d bytes, want %0d)", d, act_at(base+d), exp_at(d), act_q.size()-base, exp_q.size()); end
    tests_run++; if (max_addr != 15) begin tests_failed++; $display("FAIL s5_addr_no_wrap: got max %0d want 15", max_addr); end
  endtask

  task automatic test_status();
    logic b, d1, to;
    int base, cnt;
    base = act_q.size();
    send(3'd1, 1'b0, 4'd0, 8'h0F, 8'h00, 56'h0, 1'b1, 0, -1, 0, -1, b, d1, to);
    cnt = act_q.size() - base;
`ifdef OW_RESP_STATUS_EN
    tests_run++; if (cnt != 3 || act_at(base+2) !== 8'h80) begin tests_failed++; $display("FAIL s6_status_byte: got %0d bytes last %h want 3 bytes last 80", cnt, act_at(act_q.size()-1)); end
`else
    tests_run++; if (cnt != 2 || act_at(base+1) !== 8'h0F) begin tests_failed++; $display("FAIL s6_no_status: got %0d bytes last %h want 2 bytes last 0f", cnt, act_at(act_q.size()-1)); end
`endif
  endtask

  task automatic test_random();
    logic b, d1, to;
    logic [2:0] rd;
    int base, d, fv, bv;
    fv = full_viol;
    bv = busy_done_viol;
    for (int p = 0; p < 25; p++) begin
      for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
      case ($urandom_range(2, 0))
        0:       rd = 3'd0;
        1:       rd = 3'd2;
        default: rd = 3'($urandom);
      endcase
      base = act_q.size();
      send(rd, 1'($urandom), 4'($urandom), 8'($urandom), 8'($urandom),
           {24'($urandom), 32'($urandom)}, 1'($urandom), 30, -1, 0, -1, b, d1, to);
      d = first_diff(base);
      tests_run++; if (d >= 0 || to || b !== 1'b1 || d1 !== 1'b1) begin
        tests_failed++; $display("FAIL rand_pkt%0d: idx %0d got %h want %h (got %0d bytes want %0d, busy %b, timeout %b)", p, d, act_at(base+d), exp_at(d), act_q.size()-base, exp_q.size(), b, to);
      end
    end
    tests_run++; if (full_viol != fv) begin tests_failed++; $display("FAIL rand_write_while_full: got %0d want 0", full_viol - fv); end
    tests_run++; if (busy_done_viol != bv) begin tests_failed++; $display("FAIL rand_busy_at_done: got %0d want 0", busy_done_viol - bv); end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.fifo_full = 1'b0;
    bus.read_command = '0; bus.read_write = 1'b0; bus.data_length = '0;
    bus.ROM_command = '0; bus.Fun_cmd = '0; bus.UID_Data = '0; bus.presence = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    test_reset();
    test_rom_func();
    test_uid();
    test_data();
    test_backpressure();
    test_busy_restart_and_reset();
    test_status();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/one_wire_resp_ctrl.md
ONE_WIRE_RESP_CTRL -- requirements
Module: one_wire_resp_ctrl

Interface
REQ-001 Parameter FIFO_WIDTH, default 8, SHALL set the response FIFO byte width.
REQ-002 Parameter UID_SERIAL_DATA_WIDTH, default 56, SHALL set the UID width (7 bytes).
REQ-003 clk  in  1  SHALL be the single clock; all logic is on its rising edge.
REQ-004 rst  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 start  in  1  SHALL be a one-cycle pulse meaning the 1-wire transaction is complete and its results are valid.
REQ-006 read_command  in  3  SHALL carry the transaction type: 0 = ROM+func, 2 = UID+func, other = ROM only.
REQ-007 ROM_command  in  8  SHALL carry the ROM command byte; Fun_cmd  in  8  SHALL carry the function byte.
REQ-008 data_length  in  4  SHALL carry N, meaning N+1 data bytes; read_write  in  1  SHALL indicate that data bytes follow.
REQ-009 UID_Data  in  56  SHALL carry the UID, byte 0 in bits [7:0].
REQ-010 presence  in  1  SHALL carry the 1-wire presence-pulse result.
REQ-011 rd_address  out  5  SHALL be the data-buffer read address; rd_data  in  8  SHALL be valid one cycle after rd_address.
REQ-012 fifo_full  in  1, fifo_write_data  out  8, fifo_write_enable  out  1 SHALL form the response-FIFO write port.
REQ-013 busy  out  1  SHALL be high from the start pulse until packet completion; done  out  1  SHALL be a one-cycle completion pulse.

Function
REQ-014 On start in IDLE, the block SHALL latch all transaction inputs in that cycle, set busy the next cycle, and SHALL ignore later input changes.
REQ-015 A start pulse while busy SHALL be ignored.
REQ-016 Packet byte order SHALL be: header {data_length, read_write, read_command}; ROM_command; UID bytes 0..6 (read_command==2 only); Fun_cmd (read_command 0 or 2 only); data bytes 0..N (read_write==1 only); then the optional status byte (REQ-027).
REQ-017 States SHALL be IDLE, HDR, ROM, UID, FUNC, RD_REQ, RD_WAIT, DATA, STATUS, FINISH, with transitions in packet order; skipped sections SHALL branch directly to the next applicable state.
REQ-018 fifo_write_enable SHALL be asserted only in cycles where fifo_full is low; the pending byte and the state SHALL hold while fifo_full is high.
REQ-019 Each accepted write SHALL advance to the next byte in the next cycle, giving back-to-back throughput of one byte per cycle for header, ROM, UID and FUNC bytes.
REQ-020 A 3-bit UID counter SHALL index UID_Data[8*k +: 8] for k = 0..6 and SHALL exit UID after k = 6.
REQ-021 Data reads SHALL issue rd_address = k in RD_REQ, capture rd_data after RD_WAIT, and write it in DATA, for k = 0..N.
REQ-022 With N = 15, addresses SHALL run 0..15 and SHALL NOT wrap.
REQ-023 A data byte SHALL be held in DATA while fifo_full is high; rd_address SHALL NOT advance until the byte is written.
REQ-024 FINISH SHALL pulse done for one cycle, clear busy in the same cycle, and return to IDLE; a new start is accepted in the cycle after done.
REQ-025 fifo_write_data SHALL be registered and SHALL be valid whenever fifo_write_enable is high.

Reset
REQ-026 While rst is high: state = IDLE; busy, done and fifo_write_enable = 0; fifo_write_data, rd_address and all latches and counters = 0. A packet interrupted by rst SHALL be abandoned with no further writes.

Configuration
REQ-027 Macro OW_RESP_STATUS_EN:
- Defined: STATUS SHALL append the byte {presence, 7'b0} after the last packet byte, subject to REQ-018.
- Undefined: STATUS SHALL be omitted and the last byte SHALL go directly to FINISH.

Verification
REQ-028 Scenario 1: rd=0, rw=0, ROM=0xCC, Fun=0x44, len=0, fifo never full -> writes 0x00, 0xCC, 0x44 on consecutive cycles, then done.
REQ-029 Scenario 2: rd=2, rw=0, ROM=0x55, UID=0x0102030405060 7 (bytes 07..01) -> writes 0x02, 0x55, 0x07, 0x06, 0x05, 0x04, 0x03, 0x02, 0x01, Fun.
REQ-030 Scenario 3: rd=0, rw=1, len=3, buffer[i] = 0xA0+i -> header 0x38, ROM, Fun, then 0xA0..0xA3 from rd_address 0..3.
REQ-031 Scenario 4: fifo_full forced high for 5 cycles mid-UID -> no write during those cycles; byte held; no byte lost or duplicated.
REQ-032 Scenario 5: second start while busy, and rst asserted during DATA -> second start ignored; after rst, outputs at reset values, no further writes, next start yields a full packet.
REQ-033 Scenario 6: with OW_RESP_STATUS_EN defined and presence = 1 -> last byte is 0x80; with the macro undefined -> no status byte is written.
